// File: rtl/round_controller.sv
// round_controller
// ----------------
// Sequences one blackjack round: deals the player and dealer hands, takes
// the player's hit/stand (and optionally double-down) decisions, waits for
// the hand values to settle, then scores the round and updates the credit bank.
//
// Optional feature macro: BJ_DOUBLE_DOWN_EN
//   defined   -> double_dn accepted in PLAYER on a 2-card hand when the bank
//                covers 2*BET; wager doubles and exactly one card is drawn.
//   undefined -> double_dn is unused and the wager is always BET.
//
// Parameters
//   START_CREDITS  bank value loaded at reset
//   BET            credits wagered per round (even, <= START_CREDITS)
//   SETTLE_CYC     cycles waited after a deal/draw before sampling hand values
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start            1-cycle pulse: begin round
//   hit, stand       1-cycle pulses: player decisions
//   double_dn        1-cycle pulse: double down (feature build only)
//   player_value     ace-adjusted player hand value
//   dealer_value     dealer final hand value
//   dealer_cardsnum  dealer card count
//   deal             1-cycle strobe on the first DEAL cycle
//   new_seed         coincident with deal on every round after the first
//   player_cards     cards shown to the player (0 when idle, 2..5)
//   state            0 IDLE, 1 DEAL, 2 PLAYER, 3 DRAW, 4 DEALER, 5 SETTLE, 6 DONE
//   outcome          0 none, 1 win, 2 lose, 3 push, 4 blackjack
//   credits          credit bank
//   game_over        high while credits < BET
module round_controller #(
    parameter int unsigned START_CREDITS = 100,
    parameter int unsigned BET           = 10,
    parameter int unsigned SETTLE_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic       double_dn,
    input  logic [7:0] player_value,
    input  logic [7:0] dealer_value,
    input  logic [7:0] dealer_cardsnum,
    output logic       deal,
    output logic       new_seed,
    output logic [2:0] player_cards,
    output logic [2:0] state,
    output logic [2:0] outcome,
    output logic [9:0] credits,
    output logic       game_over
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DEAL   = 3'd1,
        ST_PLAYER = 3'd2,
        ST_DRAW   = 3'd3,
        ST_DEALER = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [2:0] OC_NONE = 3'd0;
    localparam logic [2:0] OC_WIN  = 3'd1;
    localparam logic [2:0] OC_LOSE = 3'd2;
    localparam logic [2:0] OC_PUSH = 3'd3;
    localparam logic [2:0] OC_BJ   = 3'd4;

    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);
    localparam logic [10:0]   BET_W     = 11'(BET);
    localparam logic [10:0]   BET2_W    = 11'(2 * BET);
    localparam logic [10:0]   CRED_MAX  = 11'd1023;

    state_t        state_q, state_d;
    logic [2:0]    player_cards_q, player_cards_d;
    logic [2:0]    outcome_q, outcome_d;
    logic [9:0]    credits_q, credits_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          first_q, first_d;
    logic          natural_q, natural_d;
    logic          bust_q, bust_d;
    logic          doubled_q, doubled_d;
    logic          deal_q, deal_d;
    logic          new_seed_q, new_seed_d;

    logic [10:0]   credit_ext, wager, bonus, sum_win, sum_bj;
    logic [9:0]    won_credits, bj_credits, lost_credits;
    logic          wait_done, begin_round;

`ifndef BJ_DOUBLE_DOWN_EN
    logic unused_double_dn;
    assign unused_double_dn = double_dn;
`endif

    // Saturating/flooring credit arithmetic in an 11-bit intermediate so the
    // scoring branch only has to pick one of three precomputed results.
    always_comb begin
        credit_ext   = {1'b0, credits_q};
        wager        = doubled_q ? BET2_W : BET_W;
        bonus        = wager + (wager >> 1);
        sum_win      = credit_ext + wager;
        sum_bj       = credit_ext + bonus;
        won_credits  = (sum_win > CRED_MAX) ? 10'd1023 : sum_win[9:0];
        bj_credits   = (sum_bj > CRED_MAX) ? 10'd1023 : sum_bj[9:0];
        lost_credits = (credit_ext < wager) ? 10'd0 : 10'(credit_ext - wager);
    end

    assign game_over   = (credit_ext < BET_W);
    assign wait_done   = (wait_q == WAIT_LAST);
    assign begin_round = start && !game_over;

    // Next-state and register-input logic for the whole round sequence.
    always_comb begin
        state_d        = state_q;
        player_cards_d = player_cards_q;
        outcome_d      = outcome_q;
        credits_d      = credits_q;
        wait_d         = wait_q;
        first_d        = first_q;
        natural_d      = natural_q;
        bust_d         = bust_q;
        doubled_d      = doubled_q;
        deal_d         = 1'b0;
        new_seed_d     = 1'b0;

        case (state_q)
            // DONE restarts straight into DEAL, identical to a start from IDLE.
            ST_IDLE, ST_DONE: begin
                if (begin_round) begin
                    state_d        = ST_DEAL;
                    deal_d         = 1'b1;
                    new_seed_d     = !first_q;
                    first_d        = 1'b0;
                    outcome_d      = OC_NONE;
                    player_cards_d = 3'd2;
                    wait_d         = '0;
                    natural_d      = 1'b0;
                    bust_d         = 1'b0;
                    doubled_d      = 1'b0;
                end
            end
            ST_DEAL: begin
                if (wait_done) begin
                    if (player_value == 8'd21) begin
                        natural_d = 1'b1;
                        state_d   = ST_SETTLE;
                    end else begin
                        state_d = ST_PLAYER;
                    end
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            // Stand outranks double-down, which outranks hit; a refused
            // double-down falls through to an ordinary hit check.
            ST_PLAYER: begin
                wait_d = '0;
                if (stand) begin
                    state_d = ST_DEALER;
`ifdef BJ_DOUBLE_DOWN_EN
                end else if (double_dn && player_cards_q == 3'd2 &&
                             credit_ext >= BET2_W) begin
                    doubled_d      = 1'b1;
                    player_cards_d = player_cards_q + 3'd1;
                    state_d        = ST_DRAW;
`endif
                end else if (hit) begin
                    player_cards_d = player_cards_q + 3'd1;
                    state_d        = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (wait_done) begin
                    wait_d = '0;
                    if (player_value > 8'd21) begin
                        bust_d  = 1'b1;
                        state_d = ST_SETTLE;
                    end else if (player_cards_q == 3'd5 || player_value == 8'd21 ||
                                 doubled_q) begin
                        state_d = ST_DEALER;
                    end else begin
                        state_d = ST_PLAYER;
                    end
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_DEALER: begin
                if (wait_done) begin
                    state_d = ST_SETTLE;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_DONE;
                if (bust_q) begin
                    outcome_d = OC_LOSE;
                    credits_d = lost_credits;
                end else if (natural_q) begin
                    if (dealer_value == 8'd21 && dealer_cardsnum == 8'd2) begin
                        outcome_d = OC_PUSH;
                    end else begin
                        outcome_d = OC_BJ;
                        credits_d = bj_credits;
                    end
                end else if (dealer_value > 8'd21) begin
                    outcome_d = OC_WIN;
                    credits_d = won_credits;
                end else if (player_value > dealer_value) begin
                    outcome_d = OC_WIN;
                    credits_d = won_credits;
                end else if (player_value < dealer_value) begin
                    outcome_d = OC_LOSE;
                    credits_d = lost_credits;
                end else begin
                    outcome_d = OC_PUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any round in flight without scoring it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            player_cards_q <= 3'd0;
            outcome_q      <= OC_NONE;
            credits_q      <= 10'(START_CREDITS);
            wait_q         <= '0;
            first_q        <= 1'b1;
            natural_q      <= 1'b0;
            bust_q         <= 1'b0;
            doubled_q      <= 1'b0;
            deal_q         <= 1'b0;
            new_seed_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_cards_q <= player_cards_d;
            outcome_q      <= outcome_d;
            credits_q      <= credits_d;
            wait_q         <= wait_d;
            first_q        <= first_d;
            natural_q      <= natural_d;
            bust_q         <= bust_d;
            doubled_q      <= doubled_d;
            deal_q         <= deal_d;
            new_seed_q     <= new_seed_d;
        end
    end

    assign deal         = deal_q;
    assign new_seed     = new_seed_q;
    assign player_cards = player_cards_q;
    assign state        = state_q;
    assign outcome      = outcome_q;
    assign credits      = credits_q;

endmodule

// File: tb/tb_round_controller.sv
// Testbench for round_controller: directed rounds with a round-level scoring
// model; a per-cycle compare process checks the strobes, bank and outcome.
module tb_round_controller;

   localparam int START_CREDITS = 100;
   localparam int BET           = 10;
   localparam int SETTLE_CYC    = 4;

   localparam int B_START    = 0;
   localparam int B_HIT      = 1;
   localparam int B_STAND    = 2;
   localparam int B_DOUBLE   = 3;
   localparam int B_HITSTAND = 4;

   localparam int S_IDLE   = 0;
   localparam int S_DEAL   = 1;
   localparam int S_PLAYER = 2;
   localparam int S_DRAW   = 3;
   localparam int S_DONE   = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, hit, stand, double_dn;
   logic [7:0] player_value, dealer_value, dealer_cardsnum;
   logic       deal, new_seed, game_over;
   logic [2:0] player_cards, state, outcome;
   logic [9:0] credits;

   int checks   = 0;
   int failures = 0;

   int expCredits = START_CREDITS;
   int expOutcome = 0;
   int expCards   = 0;
   int firstRound = 1;
   int prevState  = 0;

   int roundPv      = 0;
   int roundNatural = 0;
   int roundDoubled = 0;

   round_controller #(
      .START_CREDITS(START_CREDITS),
      .BET(BET),
      .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .hit(hit),
      .stand(stand),
      .double_dn(double_dn),
      .player_value(player_value),
      .dealer_value(dealer_value),
      .dealer_cardsnum(dealer_cardsnum),
      .deal(deal),
      .new_seed(new_seed),
      .player_cards(player_cards),
      .state(state),
      .outcome(outcome),
      .credits(credits),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Round scoring from the game rules, on plain integers.
   function automatic void scoreRound(input int bust, input int natural, input int pv,
                                      input int dv, input int dc, input int wager,
                                      input int creditsIn, output int oc, output int cr);
      cr = creditsIn;
      if (bust != 0) begin
         oc = 2; cr = cr - wager;
      end else if (natural != 0) begin
         if (dv == 21 && dc == 2) oc = 3;
         else begin oc = 4; cr = cr + (wager * 3) / 2; end
      end else if (dv > 21) begin
         oc = 1; cr = cr + wager;
      end else if (pv > dv) begin
         oc = 1; cr = cr + wager;
      end else if (pv < dv) begin
         oc = 2; cr = cr - wager;
      end else begin
         oc = 3;
      end
      if (cr < 0) cr = 0;
      if (cr > 1023) cr = 1023;
   endfunction

   // Per-cycle checks: deal/new_seed only on DEAL entry, bank/outcome while
   // idle or done, card count while the player is deciding.
   always @(negedge clk) begin
      if (rst) begin
         firstRound = 1;
         prevState  = S_IDLE;
      end else begin
         if (int'(state) == S_DEAL && prevState != S_DEAL) begin
            checkOutput("deal_on_entry", int'(deal), 1);
            checkOutput("new_seed_on_entry", int'(new_seed), (firstRound != 0) ? 0 : 1);
            firstRound = 0;
         end else begin
            checkOutput("deal_quiet", int'(deal), 0);
            checkOutput("new_seed_quiet", int'(new_seed), 0);
         end
         if (int'(state) == S_IDLE || int'(state) == S_DONE) begin
            checkOutput("credits", int'(credits), expCredits);
            checkOutput("outcome", int'(outcome), expOutcome);
            checkOutput("game_over", int'(game_over), (expCredits < BET) ? 1 : 0);
         end
         if (int'(state) == S_PLAYER)
            checkOutput("player_cards", int'(player_cards), expCards);
         prevState = int'(state);
      end
   end

   // Drives one 1-cycle button pulse along with a new player hand value.
   task automatic applyStimulus(input int btn, input int pv);
      player_value = 8'(pv);
      case (btn)
         B_START:    start = 1'b1;
         B_HIT:      hit = 1'b1;
         B_STAND:    stand = 1'b1;
         B_DOUBLE:   double_dn = 1'b1;
         B_HITSTAND: begin hit = 1'b1; stand = 1'b1; end
         default:    ;
      endcase
      @(posedge clk); #1;
      start = 1'b0; hit = 1'b0; stand = 1'b0; double_dn = 1'b0;
   endtask

   task automatic waitState(input int target, input int budget, input string name);
      int n = 0;
      while (int'(state) != target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, int'(state), target);
   endtask

   task automatic startRound(input int pv, input int dv, input int dc);
      dealer_value    = 8'(dv);
      dealer_cardsnum = 8'(dc);
      applyStimulus(B_START, pv);
      expOutcome   = 0;
      expCards     = 2;
      roundPv      = pv;
      roundNatural = (pv == 21) ? 1 : 0;
      roundDoubled = 0;
   endtask

   task automatic hitCard(input int pv);
      applyStimulus(B_HIT, pv);
      expCards++;
      roundPv = pv;
   endtask

   task automatic finishRound();
      int oc, cr;
      scoreRound((roundPv > 21) ? 1 : 0, roundNatural, roundPv, int'(dealer_value),
                 int'(dealer_cardsnum), (roundDoubled != 0) ? 2 * BET : BET,
                 expCredits, oc, cr);
      expOutcome = oc;
      expCredits = cr;
      waitState(S_DONE, 60, "reach_done");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hit = 1'b0; stand = 1'b0; double_dn = 1'b0;
      player_value = 8'd0; dealer_value = 8'd0; dealer_cardsnum = 8'd2;
      #12;
      checkOutput("rst_state", int'(state), 0);
      checkOutput("rst_credits", int'(credits), 100);
      checkOutput("rst_cards", int'(player_cards), 0);
      checkOutput("rst_outcome", int'(outcome), 0);
      checkOutput("rst_deal", int'(deal), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Natural 21 against a 3-card 19: blackjack pays 3:2.
      startRound(21, 19, 3);
      finishRound();
      checkOutput("bj_outcome", int'(outcome), 4);
      checkOutput("bj_credits", int'(credits), 115);

      // Bust on a hit; dealer value 30 would otherwise mean a win.
      startRound(12, 30, 3);
      waitState(S_PLAYER, 20, "reach_player");
      hitCard(23);
      finishRound();
      checkOutput("bust_outcome", int'(outcome), 2);
      checkOutput("bust_credits", int'(credits), 105);

      // Stand on 18: push against 18, win against a dealer bust.
      startRound(18, 18, 2);
      waitState(S_PLAYER, 20, "reach_player");
      applyStimulus(B_STAND, 18);
      finishRound();
      checkOutput("push_outcome", int'(outcome), 3);
      checkOutput("push_credits", int'(credits), 105);
      startRound(18, 22, 3);
      waitState(S_PLAYER, 20, "reach_player");
      applyStimulus(B_STAND, 18);
      finishRound();
      checkOutput("dbust_outcome", int'(outcome), 1);
      checkOutput("dbust_credits", int'(credits), 115);

      // Five-card hand at 20 stands automatically and beats 18.
      startRound(5, 18, 3);
      waitState(S_PLAYER, 20, "reach_player");
      hitCard(9);
      waitState(S_PLAYER, 20, "reach_player");
      hitCard(13);
      waitState(S_PLAYER, 20, "reach_player");
      hitCard(20);
      finishRound();
      checkOutput("five_cards", int'(player_cards), 5);
      checkOutput("five_outcome", int'(outcome), 1);
      checkOutput("five_credits", int'(credits), 125);

      // Hit and stand together: stand wins, no card drawn, 17 loses to 19.
      startRound(17, 19, 2);
      waitState(S_PLAYER, 20, "reach_player");
      applyStimulus(B_HITSTAND, 17);
      finishRound();
      checkOutput("hs_cards", int'(player_cards), 2);
      checkOutput("hs_outcome", int'(outcome), 2);
      checkOutput("hs_credits", int'(credits), 115);

      // Reset in the middle of a draw discards the round.
      startRound(12, 20, 2);
      waitState(S_PLAYER, 20, "reach_player");
      hitCard(15);
      @(posedge clk); #1;
      checkOutput("in_draw", int'(state), S_DRAW);
      #1 rst = 1'b1;
      #1;
      checkOutput("mid_rst_state", int'(state), 0);
      checkOutput("mid_rst_credits", int'(credits), 100);
      checkOutput("mid_rst_cards", int'(player_cards), 0);
      checkOutput("mid_rst_outcome", int'(outcome), 0);
      expCredits = START_CREDITS; expOutcome = 0; expCards = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

`ifdef BJ_DOUBLE_DOWN_EN
      // Double on 11, draw to 21, beat 20: doubled wager won.
      startRound(11, 20, 2);
      waitState(S_PLAYER, 20, "reach_player");
      applyStimulus(B_DOUBLE, 21);
      expCards = 3; roundPv = 21; roundDoubled = 1;
      finishRound();
      checkOutput("dd_cards", int'(player_cards), 3);
      checkOutput("dd_outcome", int'(outcome), 1);
      checkOutput("dd_credits", int'(credits), 120);
`endif

      // Lose until the bank is empty, then start must be ignored.
      for (int r = 0; r < 20 && expCredits >= BET; r++) begin
         startRound(10, 20, 2);
         waitState(S_PLAYER, 20, "reach_player");
         applyStimulus(B_STAND, 10);
         finishRound();
      end
      checkOutput("empty_credits", int'(credits), 0);
      checkOutput("empty_game_over", int'(game_over), 1);
      applyStimulus(B_START, 10);
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("start_ignored", int'(state), S_DONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
